// File: rtl/ps2_key_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_event_arbiter
//  Description : Decodes the PS/2 scancode byte stream into held state and
//                press/release pulses for space, enter, '1' and '2', and
//                shares the pulses among NUM_CLIENTS game modules through a
//                round-robin ownership arbiter with an idle timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_event_arbiter #(
    parameter int NUM_CLIENTS    = 2,
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int TW             = 26
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [NUM_CLIENTS-1:0] rel,
    output logic [NUM_CLIENTS-1:0] grant,
    output logic [3:0]             key_held,
    output logic [3:0]             key_press,
    output logic [3:0]             key_release
);

    localparam int            PW      = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_ENTER = 8'h5A;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_BREAK     = 2'd1,
        S_EXT       = 2'd2,
        S_EXT_BREAK = 2'd3
    } state_t;

    // Registered state
    state_t                 state_q, state_d;
    logic [3:0]             held_q, held_d;
    logic [3:0]             press_q, press_d;
    logic [3:0]             release_q, release_d;
    logic [NUM_CLIENTS-1:0] grant_q, grant_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [TW-1:0]          cnt_q, cnt_d;

    // Decoder results for the current byte
    logic [3:0] make_v;
    logic [3:0] brk_v;
    logic [3:0] press_evt;
    logic [3:0] release_evt;
    logic       held_chg;
    logic       owner_end;

    // Non-extended table lookup; enter is reachable both plain and E0-prefixed
    function automatic logic [3:0] key_onehot(input logic [7:0] code);
        case (code)
            8'h29:   key_onehot = 4'b0001;
            8'h5A:   key_onehot = 4'b0010;
            8'h16:   key_onehot = 4'b0100;
            8'h1E:   key_onehot = 4'b1000;
            default: key_onehot = 4'b0000;
        endcase
    endfunction

    // Scancode prefix decoder: advances only on accepted bytes
    always_comb begin
        state_d = state_q;
        make_v  = 4'b0000;
        brk_v   = 4'b0000;
        if (rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data == CODE_BREAK)    state_d = S_BREAK;
                    else if (rx_data == CODE_EXT) state_d = S_EXT;
                    else                          make_v  = key_onehot(rx_data);
                end
                S_BREAK: begin
                    if (rx_data == CODE_BREAK) begin
                        state_d = S_BREAK;
                    end else if (rx_data == CODE_EXT) begin
                        state_d = S_EXT_BREAK;
                    end else begin
                        brk_v   = key_onehot(rx_data);
                        state_d = S_IDLE;
                    end
                end
                S_EXT: begin
                    if (rx_data == CODE_ENTER) begin
                        make_v  = 4'b0010;
                        state_d = S_IDLE;
                    end else if (rx_data == CODE_BREAK) begin
                        state_d = S_EXT_BREAK;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_EXT_BREAK: begin
                    if (rx_data == CODE_ENTER) brk_v = 4'b0010;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Held state and edge events; typematic repeats and stray breaks drop out here
    always_comb begin
        press_evt   = make_v & ~held_q;
        release_evt = brk_v & held_q;
        held_d      = (held_q | make_v) & ~brk_v;
        held_chg    = |(press_evt | release_evt);
    end

    // Ownership arbiter: hold, revoke, or pick next requester round-robin
    always_comb begin
        int   idx;
        logic found;
        idx       = 0;
        found     = 1'b0;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        owner_end = (|(rel & grant_q)) || !(|(req & grant_q)) || (cnt_q == TO_LAST);
        if (|grant_q) begin
            if (owner_end) grant_d = '0;
        end else if (|req) begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                idx = (int'(ptr_q) + i) % NUM_CLIENTS;
                if (!found && (|(req & (NUM_CLIENTS'(1) << idx)))) begin
                    found   = 1'b1;
                    grant_d = NUM_CLIENTS'(1) << idx;
                    ptr_d   = PW'((idx + 1) % NUM_CLIENTS);
                end
            end
        end
    end

    // Idle timeout counter and owner-gated event pulses
    always_comb begin
        if ((grant_d == '0) || (grant_q == '0) || held_chg) cnt_d = '0;
        else if (cnt_q != '1)                               cnt_d = cnt_q + 1'b1;
        else                                                cnt_d = cnt_q;
        // A pulse exists only if someone owns the keyboard in the cycle it shows
        press_d   = (|grant_d) ? press_evt   : 4'b0000;
        release_d = (|grant_d) ? release_evt : 4'b0000;
    end

    // All state registers; async reset abandons any partial scancode sequence
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            held_q    <= 4'b0000;
            press_q   <= 4'b0000;
            release_q <= 4'b0000;
            grant_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            held_q    <= held_d;
            press_q   <= press_d;
            release_q <= release_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign grant       = grant_q;
    assign key_held    = held_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_key_event_arbiter
//  Description : Directed self-checking bench for ps2_key_event_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_event_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [1:0] req;
    logic [1:0] rel;

    logic [1:0] b_grant, t_grant;
    logic [3:0] b_held, b_press, b_release;
    logic [3:0] t_held, t_press, t_release;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Long-timeout instance for decoder and arbiter checks
    ps2_key_event_arbiter #(
        .NUM_CLIENTS(2), .TIMEOUT_CYCLES(1000), .TW(10)
    ) u_big (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .req(req), .rel(rel), .grant(b_grant), .key_held(b_held),
        .key_press(b_press), .key_release(b_release)
    );

    // Short-timeout instance for ownership revocation checks
    ps2_key_event_arbiter #(
        .NUM_CLIENTS(2), .TIMEOUT_CYCLES(16), .TW(5)
    ) u_to (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .req(req), .rel(rel), .grant(t_grant), .key_held(t_held),
        .key_press(t_press), .key_release(t_release)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        req      = 2'b00;
        rel      = 2'b00;
        tick();
        tick();
        chk("rst_grant",   32'(b_grant),   32'h0);
        chk("rst_held",    32'(b_held),    32'h0);
        chk("rst_press",   32'(b_press),   32'h0);
        chk("rst_release", 32'(b_release), 32'h0);
        reset = 1'b0;
        tick();

        // Grant and typematic filtering
        req = 2'b01;
        tick();
        chk("grant_first", 32'(b_grant), 32'h1);
        send(8'h29);
        chk("space_press", 32'(b_press), 32'h1);
        chk("space_held",  32'(b_held),  32'h1);
        send(8'h29);
        chk("repeat_nopulse1", 32'(b_press), 32'h0);
        send(8'h29);
        chk("repeat_nopulse2", 32'(b_press), 32'h0);
        chk("repeat_held",     32'(b_held),  32'h1);

        // Break of held space, then break of a non-held key
        send(8'hF0);
        chk("f0_no_release", 32'(b_release), 32'h0);
        send(8'h29);
        chk("space_release", 32'(b_release), 32'h1);
        chk("space_unheld",  32'(b_held),    32'h0);
        tick();
        chk("release_one_cycle", 32'(b_release), 32'h0);
        send(8'hF0);
        send(8'h16);
        chk("stray_break_release", 32'(b_release), 32'h0);
        chk("stray_break_held",    32'(b_held),    32'h0);

        // Extended enter, and an ignored extended code
        send(8'hE0);
        send(8'h5A);
        chk("enter_press", 32'(b_press), 32'h2);
        chk("enter_held",  32'(b_held),  32'h2);
        send(8'hE0);
        send(8'hF0);
        send(8'h5A);
        chk("enter_release", 32'(b_release), 32'h2);
        chk("enter_unheld",  32'(b_held),    32'h0);
        send(8'hE0);
        send(8'h29);
        chk("ext29_held",  32'(b_held),  32'h0);
        chk("ext29_press", 32'(b_press), 32'h0);
        send(8'h29);
        chk("idle_after_ext_press", 32'(b_press), 32'h1);
        send(8'hF0);
        send(8'h29);
        chk("idle_after_ext_rel", 32'(b_release), 32'h1);

        // Round-robin with release pulses, pointer starting at 0
        req = 2'b00;
        do_reset();
        req = 2'b11;
        tick();
        chk("rr_grant0", 32'(b_grant), 32'h1);
        rel = 2'b01;
        tick();
        rel = 2'b00;
        chk("rr_gap1", 32'(b_grant), 32'h0);
        tick();
        chk("rr_grant1", 32'(b_grant), 32'h2);
        rel = 2'b10;
        tick();
        rel = 2'b00;
        chk("rr_gap2", 32'(b_grant), 32'h0);
        tick();
        chk("rr_wrap", 32'(b_grant), 32'h1);

        // Release coinciding with a key make drops the pulse, keeps held
        rel      = 2'b01;
        rx_data  = 8'h1E;
        rx_valid = 1'b1;
        tick();
        rel      = 2'b00;
        rx_valid = 1'b0;
        chk("relkey_grant", 32'(b_grant), 32'h0);
        chk("relkey_press", 32'(b_press), 32'h0);
        chk("relkey_held",  32'(b_held),  32'h8);
        tick();
        chk("relkey_regrant", 32'(b_grant), 32'h2);

        // Timeout revocation on the short-timeout instance
        req = 2'b00;
        do_reset();
        req = 2'b01;
        tick();
        chk("to_grant", 32'(t_grant), 32'h1);
        for (int i = 0; i < 15; i++) tick();
        chk("to_still_granted", 32'(t_grant), 32'h1);
        rx_data  = 8'h29;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        chk("to_revoked",  32'(t_grant), 32'h0);
        chk("to_no_press", 32'(t_press), 32'h0);
        chk("to_held",     32'(t_held),  32'h1);
        tick();
        chk("to_regrant",       32'(t_grant), 32'h1);
        chk("to_regrant_press", 32'(t_press), 32'h0);

        // Asynchronous reset after a break prefix
        send(8'hF0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_grant", 32'(b_grant), 32'h0);
        chk("async_held",  32'(b_held),  32'h0);
        chk("async_tgrant", 32'(t_grant), 32'h0);
        reset = 1'b0;
        tick();
        chk("post_rst_grant", 32'(b_grant), 32'h1);
        send(8'h29);
        chk("post_rst_press", 32'(b_press), 32'h1);
        chk("post_rst_held",  32'(b_held),  32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
